// File: rtl/rep_window_sequencer_if.sv
// rtl/rep_window_sequencer_if.sv - control, monitored-signal and verdict bundle for the repetition sequencer
interface rep_window_sequencer_if #(
  parameter int REP_W = 4,
  parameter int WIN_W = 8
);
  logic             start;
  logic             abort;
  logic [1:0]       mode;
  logic [REP_W-1:0] rep_n;
  logic [WIN_W-1:0] window;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [REP_W-1:0] match_cnt;

  modport master (
    output start, abort, mode, rep_n, window, a, b,
    input  busy, done, pass, fail, match_cnt
  );

  modport slave (
    input  start, abort, mode, rep_n, window, a, b,
    output busy, done, pass, fail, match_cnt
  );
endinterface

// File: rtl/rep_window_sequencer.sv
// rtl/rep_window_sequencer.sv - arms, runs and scores one [*N]/[->N]/[=N] check of a&b over a window
module rep_window_sequencer #(
  parameter int REP_W = 4,
  parameter int WIN_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  rep_window_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [1:0]       mode_q;
  logic [REP_W-1:0] rep_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cyc;
  logic [REP_W-1:0] cnt;
  logic             pass_q;
  logic             fail_q;
  logic             done_q;

  logic             hit;
  logic             cnt_sat;
  logic [REP_W-1:0] cnt_nxt;
  logic [WIN_W-1:0] cyc_nxt;
  logic             last;
  logic             v_pass;
  logic             v_fail;

  assign hit     = bus.a & bus.b;
  assign cnt_sat = &cnt;
  assign cnt_nxt = (hit && !cnt_sat) ? cnt + 1'b1 : cnt;
  assign cyc_nxt = cyc + 1'b1;
  assign last    = (cyc_nxt == win_q);

  // Verdict for the current sampled cycle, judged on the count including this cycle's hit
  always_comb begin
    v_pass = 1'b0;
    v_fail = 1'b0;
    case (mode_q)
      2'd0: begin
        // Consecutive: any miss before reaching N ends the check
        if (rep_q == '0 || cnt_nxt == rep_q) v_pass = 1'b1;
        else if (!hit || last)               v_fail = 1'b1;
      end
      2'd1: begin
        // Goto: misses are tolerated until the window closes
        if (rep_q == '0 || cnt_nxt == rep_q) v_pass = 1'b1;
        else if (last)                       v_fail = 1'b1;
      end
      default: begin
        // Non-consecutive: an (N+1)th hit fails at once; a saturated counter
        // means N is the maximum and N+1 can never be observed
        if (hit && cnt == rep_q && !cnt_sat) v_fail = 1'b1;
        else if (last) begin
          if (cnt_nxt == rep_q) v_pass = 1'b1;
          else                  v_fail = 1'b1;
        end
      end
    endcase
  end

  // Sequencer state, latched config, counters and held verdict
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= '0;
      rep_q  <= '0;
      win_q  <= '0;
      cyc    <= '0;
      cnt    <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            rep_q  <= bus.rep_n;
            win_q  <= (bus.window == '0) ? WIN_ONE : bus.window;
            cyc    <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            cyc <= cyc_nxt;
            cnt <= cnt_nxt;
            if (v_pass || v_fail) begin
              pass_q <= v_pass;
              fail_q <= v_fail;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.match_cnt = cnt;

endmodule
